seq_multiplier_param: RTL and testbench



---
 rtl/seq_multiplier_param.sv | 124 ++++++++++++
 tb/tb_seq_multiplier_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: iterative shift-and-add multiplier with a WIDTH
// parameter, signed/unsigned mode per operation, a busy flag, and a held
// registered result. The controller FSM, iteration counter and datapath
// all live in this one module.
module seq_multiplier_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mreg_q, mreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Operand magnitudes. In signed mode a negative operand is negated at
    // WIDTH bits; the most negative value wraps onto itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             a_neg, b_neg;

    // Magnitude and sign extraction for the operands at the accept edge
    always_comb begin
        a_neg = signed_mode & multiplicand[WIDTH-1];
        b_neg = signed_mode & multiplier[WIDTH-1];
        a_abs = a_neg ? (~multiplicand + 1'b1) : multiplicand;
        b_abs = b_neg ? (~multiplier + 1'b1) : multiplier;
    end

    // Next-state and datapath: accept in IDLE, one add/shift per CALC
    // cycle, apply the sign and publish the product in FIN
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mreg_d   = mreg_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (init) begin
                    mcand_d = {{WIDTH{1'b0}}, a_abs};
                    mreg_d  = b_abs;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mreg_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mreg_d  = mreg_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Full 2*WIDTH product is exact, so negation never overflows.
                result_d = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation and clears the result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mreg_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mreg_q   <= mreg_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param: directed vector table plus hand-written
// sequences on a 16-bit instance, and model-checked pairs on 4- and 8-bit
// instances running side by side.
module tb_seq_multiplier_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        init = 1'b0, sm = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [31:0] result;
    logic        busy, done;

    logic        init4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  result4;
    logic        busy4, done4;

    logic        init8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] result8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier_param #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .init(init), .signed_mode(sm),
        .multiplicand(a), .multiplier(b),
        .result(result), .busy(busy), .done(done));

    seq_multiplier_param #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .init(init4), .signed_mode(sm4),
        .multiplicand(a4), .multiplier(b4),
        .result(result4), .busy(busy4), .done(done4));

    seq_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .init(init8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .result(result8), .busy(busy8), .done(done8));

    typedef struct {
        logic        sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Edges until done is seen high (sampled 1 unit after each edge),
    // bounded; also counts busy-high samples before done.
    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nb++;
        end while (!done && n < 100);
    endtask

    task automatic op16(input vec_t v);
        int n, nb;
        @(negedge clk);
        init = 1'b1; sm = v.sm; a = v.a; b = v.b;
        @(posedge clk);
        #1;
        init = 1'b0;
        chk({v.name, " busy_at_accept"}, 64'(busy), 64'd1);
        wait_done(n, nb);
        chk({v.name, " latency"}, 64'(n), 64'd17);
        chk({v.name, " busy_cycles"}, 64'(nb + 1), 64'd17);
        chk({v.name, " result"}, 64'(result), 64'(v.exp));
        @(posedge clk);
        #1;
        chk({v.name, " done_one_cycle"}, 64'(done), 64'd0);
        chk({v.name, " result_held"}, 64'(result), 64'(v.exp));
    endtask

    initial begin
        vec_t vt[10];
        int n, nb, dcnt;

        vt[0] = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F, "u3x5"};
        vt[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "uFFFFxFFFF"};
        vt[2] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000, "u0x1234"};
        vt[3] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "s-3x5"};
        vt[4] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, "sMINxMIN"};
        vt[5] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, "sMINx1"};
        vt[6] = '{1'b0, 16'hFFFD, 16'h0005, 32'h0004FFF1, "uFFFDx5"};
        vt[7] = '{1'b1, 16'hFFFD, 16'hFFFB, 32'h0000000F, "s-3x-5"};
        vt[8] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, "sMAXxMIN"};
        vt[9] = '{1'b0, 16'h8000, 16'h0002, 32'h00010000, "u8000x2"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset result", 64'(result), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        for (int i = 0; i < 10; i++) op16(vt[i]);

        // init held high, operands change mid-operation, then back-to-back
        @(negedge clk);
        init = 1'b1; sm = 1'b0; a = 16'd7; b = 16'd9;
        @(posedge clk);
        #1;
        chk("hold busy_at_accept", 64'(busy), 64'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 16'd100; b = 16'd100;
        wait_done(n, nb);
        chk("hold latency", 64'(n), 64'd12);
        chk("hold result", 64'(result), 64'h3F);
        @(posedge clk);
        #1;
        chk("b2b accepted busy", 64'(busy), 64'd1);
        chk("b2b done_low", 64'(done), 64'd0);
        chk("b2b result_held", 64'(result), 64'h3F);
        @(negedge clk);
        init = 1'b0;
        wait_done(n, nb);
        chk("b2b latency", 64'(n), 64'd17);
        chk("b2b result", 64'(result), 64'd10000);

        // reset in the middle of 7*9
        @(negedge clk);
        init = 1'b1; a = 16'd7; b = 16'd9;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort no_done", 64'(dcnt), 64'd0);
        op16('{1'b0, 16'd7, 16'd9, 32'h0000003F, "fresh7x9"});

        // 4- and 8-bit instances against an integer reference product
        for (int i = 0; i < 20; i++) begin
            int sa, sb, l4, l8, k;
            logic [7:0]  e4;
            logic [15:0] e8;
            @(negedge clk);
            if (i == 0) begin
                sm4 = 1'b1; a4 = 4'h8; b4 = 4'h8;
                sm8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
            end else begin
                sm4 = 1'($urandom_range(0, 1)); a4 = 4'($urandom); b4 = 4'($urandom);
                sm8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
            end
            sa = sm4 ? int'($signed(a4)) : int'(a4);
            sb = sm4 ? int'($signed(b4)) : int'(b4);
            e4 = 8'(sa * sb);
            sa = sm8 ? int'($signed(a8)) : int'(a8);
            sb = sm8 ? int'($signed(b8)) : int'(b8);
            e8 = 16'(sa * sb);
            init4 = 1'b1; init8 = 1'b1;
            @(posedge clk);
            #1;
            init4 = 1'b0; init8 = 1'b0;
            l4 = 0; l8 = 0; k = 0;
            while ((l4 == 0 || l8 == 0) && k < 40) begin
                @(posedge clk);
                #1;
                k++;
                if (done4 && l4 == 0) l4 = k;
                if (done8 && l8 == 0) l8 = k;
            end
            chk($sformatf("w4 latency #%0d", i), 64'(l4), 64'd5);
            chk($sformatf("w8 latency #%0d", i), 64'(l8), 64'd9);
            chk($sformatf("w4 result #%0d sm=%0d %0h*%0h", i, sm4, a4, b4), 64'(result4), 64'(e4));
            chk($sformatf("w8 result #%0d sm=%0d %0h*%0h", i, sm8, a8, b8), 64'(result8), 64'(e8));
            if (i == 0) chk("w4 -8x-8", 64'(result4), 64'h40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
